// File: rtl/sensor_pkg.sv
// Shared constants and state type for the sensor debounce stage.
package sensor_pkg;

   localparam int NUM_SENSORS_DEF     = 4;
   localparam int CNT_W_DEF           = 4;
   localparam int DEBOUNCE_CYCLES_DEF = 10;

   typedef enum logic {
      STABLE  = 1'b0,
      PENDING = 1'b1
   } dbnc_state_t;

endpackage

// File: rtl/sensor_debounce_bit.sv
// One sensor line: 2-flop synchronizer, persistence counter, STABLE/PENDING FSM
// and the registered debounced level.
module sensor_debounce_bit
   import sensor_pkg::*;
#(
   parameter int CNT_W           = CNT_W_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic sample_en,
   input  logic raw,
   output logic level,
   output logic flip,
   output logic idle
);

   localparam logic [CNT_W-1:0] LAST      = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam bit               IMMEDIATE = (DEBOUNCE_CYCLES == 1);

   logic             s1;
   logic             s2;
   dbnc_state_t      state;
   logic [CNT_W-1:0] cnt;

   // Strobe is true exactly in the cycle whose edge will toggle level.
   always_comb begin
      flip = 1'b0;
      if (sample_en && (s2 != level)) begin
         if (state == STABLE)
            flip = IMMEDIATE;
         else
            flip = (cnt == LAST);
      end
   end

   assign idle = (state == STABLE) && (s2 == level);

   // NOTE: all state uses non-blocking assignments so every flop samples
   // pre-edge values; blocking here would collapse the synchronizer stages.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         state <= STABLE;
         cnt   <= '0;
         level <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
         if (sample_en) begin
            if (state == STABLE) begin
               if (s2 != level) begin
                  if (IMMEDIATE) begin
                     level <= ~level;
                  end else begin
                     state <= PENDING;
                     cnt   <= CNT_W'(1);
                  end
               end
            end else begin
               if (s2 == level) begin
                  state <= STABLE;
                  cnt   <= '0;
               end else if (cnt == LAST) begin
                  level <= ~level;
                  state <= STABLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
         end
      end
   end

endmodule

// File: rtl/sensor_debounce.sv
// Per-bit synchronize-and-debounce of the raw sensor lines with change pulse and
// all-settled flag. Optional saturating edge counter under `SENSOR_EDGE_CNT_EN.
module sensor_debounce
   import sensor_pkg::*;
#(
   parameter int NUM_SENSORS     = NUM_SENSORS_DEF,
   parameter int CNT_W           = CNT_W_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   sample_en,
   input  logic [NUM_SENSORS-1:0] raw_sensors,
   output logic [NUM_SENSORS-1:0] sensors,
   output logic                   changed,
   output logic                   stable
`ifdef SENSOR_EDGE_CNT_EN
   ,
   input  logic                   clear_count,
   output logic [7:0]             edge_count
`endif
);

   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (1 << CNT_W) - 1) begin : g_bad_param
      $error("sensor_debounce: DEBOUNCE_CYCLES out of range for CNT_W");
   end

   logic [NUM_SENSORS-1:0] flip;
   logic [NUM_SENSORS-1:0] idle;

   for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_bit
      sensor_debounce_bit #(
         .CNT_W           (CNT_W),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_bit (
         .clk       (clk),
         .rst       (rst),
         .sample_en (sample_en),
         .raw       (raw_sensors[i]),
         .level     (sensors[i]),
         .flip      (flip[i]),
         .idle      (idle[i])
      );
   end

   // Simultaneous flips on several bits merge into one pulse.
   always_ff @(posedge clk) begin
      if (rst)
         changed <= 1'b0;
      else
         changed <= |flip;
   end

   assign stable = &idle;

`ifdef SENSOR_EDGE_CNT_EN
   always_ff @(posedge clk) begin
      if (rst || clear_count)
         edge_count <= 8'd0;
      else if (changed && (edge_count != 8'hFF))
         edge_count <= edge_count + 8'd1;
   end
`endif

endmodule
